// File: rtl/key_uart_tx.sv
// UART transmitter for decoded key codes: one 8N1 frame per accepted byte (8E1 when
// KEY_UART_TX_PARITY_EN is defined). o_ready is low for the whole frame.
module key_uart_tx #(
    parameter int unsigned CLK_HZ = 27_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DIV    = CLK_HZ / BAUD
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

`ifdef KEY_UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_end;
`ifdef KEY_UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef KEY_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (i_valid) begin
                    state_d = StStart;
                    shift_d = i_data;
                    idx_d   = 3'd0;
`ifdef KEY_UART_TX_PARITY_EN
                    parity_d = ^i_data;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef KEY_UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef KEY_UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    cnt_d   = '0;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Line level is computed for the upcoming cycle so o_tx comes straight from a flop.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef KEY_UART_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
`ifdef KEY_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef KEY_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = (state_q == StIdle);
    assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_key_uart_tx.sv
// Directed self-checking bench for key_uart_tx at DIV=4; outputs sampled on the falling edge.
module tb_key_uart_tx;

    localparam int DIV = 4;
`ifdef KEY_UART_TX_PARITY_EN
    localparam int F = 11 * DIV;
`else
    localparam int F = 10 * DIV;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    int         total;
    int         bad;

    key_uart_tx #(.DIV(DIV)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready),
        .o_tx    (tx),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level k cycles after the accepting edge of byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        int b;
        b = k / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef KEY_UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            total++;
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset[%0d]: tx=%b ready=%b busy=%b, want 1 1 0", i, tx, ready, busy);
            end
        end
        @(negedge clk);
        total++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_after: tx=%b ready=%b busy=%b, want 1 1 0", tx, ready, busy);
        end
    endtask

    task automatic test_single();
        int lows;
        lows  = 0;
        valid = 1'b1;
        data  = 8'h41;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int k = 0; k <= F; k++) begin
            @(negedge clk);
            if (ready === 1'b0) lows++;
            total++;
            if (tx !== exp_bit(8'h41, k)) begin
                bad++;
                $display("FAIL single_tx[%0d]: tx=%b want %b", k, tx, exp_bit(8'h41, k));
            end
            total++;
            if (ready !== (k == F) || busy !== (k != F)) begin
                bad++;
                $display("FAIL single_hs[%0d]: ready=%b busy=%b want %b %b", k, ready, busy,
                         k == F, k != F);
            end
        end
        total++;
        if (lows != F) begin
            bad++;
            $display("FAIL single_ready_low: cycles=%0d want %0d", lows, F);
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        valid = 1'b1;
        data  = 8'h55;
        @(posedge clk);
        #1 data = 8'hAA;
        for (int k = 0; k < 2 * F + 5; k++) begin
            @(negedge clk);
            if (k < F) e = exp_bit(8'h55, k);
            else if (k > F && k <= 2 * F) e = exp_bit(8'hAA, k - F - 1);
            else e = 1'b1;
            total++;
            if (tx !== e) begin
                bad++;
                $display("FAIL b2b_tx[%0d]: tx=%b want %b", k, tx, e);
            end
            total++;
            if (ready !== (k == F || k > 2 * F)) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: ready=%b want %b", k, ready, k == F || k > 2 * F);
            end
            if (k == F + 1) valid = 1'b0;
        end
    endtask

    task automatic test_ignore_busy();
        logic e;
        for (int hold = 0; hold < 2; hold++) begin
            valid = 1'b1;
            data  = 8'h00;
            @(posedge clk);
            #1 valid = 1'b0;
            for (int k = 0; k < 2 * F + 5; k++) begin
                @(negedge clk);
                if (k < F) e = exp_bit(8'h00, k);
                else if (hold == 1 && k > F && k <= 2 * F) e = exp_bit(8'hFF, k - F - 1);
                else e = 1'b1;
                total++;
                if (tx !== e) begin
                    bad++;
                    $display("FAIL ignore%0d_tx[%0d]: tx=%b want %b", hold, k, tx, e);
                end
                data = 8'hFF;
                if (k >= 2 && k < F - 3) valid = k[0];
                else if (k == F - 3) valid = (hold == 1);
                else if (k == F + 1) valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        valid = 1'b1;
        data  = 8'h00;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int k = 0; k < F + 10; k++) begin
            @(negedge clk);
            total++;
            if (k < 18) begin
                if (tx !== exp_bit(8'h00, k) || ready !== 1'b0) begin
                    bad++;
                    $display("FAIL midrst_pre[%0d]: tx=%b ready=%b want %b 0", k, tx, ready,
                             exp_bit(8'h00, k));
                end
            end else if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midrst_post[%0d]: tx=%b ready=%b busy=%b want 1 1 0", k, tx,
                         ready, busy);
            end
            // Sample 17 sits inside data bit 3.
            if (k == 17) rst = 1'b1;
            if (k == 18) rst = 1'b0;
        end
    endtask

    task automatic test_reset_accept();
        valid = 1'b1;
        data  = 8'h5A;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_accept[%0d]: tx=%b ready=%b busy=%b want 1 1 0", i, tx,
                         ready, busy);
            end
            @(negedge clk);
        end
    endtask

`ifdef KEY_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       pars  [2];
        bytes[0] = 8'h07; pars[0] = 1'b1;
        bytes[1] = 8'h03; pars[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            valid = 1'b1;
            data  = bytes[j];
            @(posedge clk);
            #1 valid = 1'b0;
            for (int k = 0; k <= F; k++) begin
                @(negedge clk);
                total++;
                if (tx !== exp_bit(bytes[j], k)) begin
                    bad++;
                    $display("FAIL parity_tx %h[%0d]: tx=%b want %b", bytes[j], k, tx,
                             exp_bit(bytes[j], k));
                end
                if (k / DIV == 9) begin
                    total++;
                    if (tx !== pars[j]) begin
                        bad++;
                        $display("FAIL parity_bit %h[%0d]: tx=%b want %b", bytes[j], k, tx,
                                 pars[j]);
                    end
                end
                total++;
                if (ready !== (k == F)) begin
                    bad++;
                    $display("FAIL parity_len %h[%0d]: ready=%b want %b", bytes[j], k, ready,
                             k == F);
                end
            end
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_reset_accept();
`ifdef KEY_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
